// File: rtl/output_pad_streamer.sv
// Core-to-pad streamer: buffers core words in a small FIFO and shows each on the output pads with a held strobe.
// Optional OUTPUT_PARITY_EN: the top data bit carries even parity of the lower data bits instead of in_data[DW-1].
module output_pad_streamer #(
    parameter int NUM_OUTPUT_PADS = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_OUTPUT_PADS-2:0]    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_OUTPUT_PADS-1:0]    output_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam int DW = NUM_OUTPUT_PADS - 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          strobe_q, strobe_d;
    logic [DW-1:0] wr_word;
    logic          push;
    logic          pop;

`ifdef OUTPUT_PARITY_EN
    logic unused_top_bit;
    assign unused_top_bit = in_data[DW-1];
    assign wr_word = {^in_data[DW-2:0], in_data[DW-2:0]};
`else
    assign wr_word = in_data;
`endif

    // Ready comes from the registered level only, so a full FIFO never takes a word even on a popping edge.
    assign in_ready   = (level_q < FULL_LVL);
    assign push       = in_valid && in_ready;
    assign pop        = ((state_q == IDLE) || (state_q == GAP)) && (level_q != '0);
    assign fifo_level = level_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign output_out = {strobe_q, data_q};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    // Data only reloads on the way into SETUP, so the pads never change under a high strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = HOLD_LOAD;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        strobe_d = (state_d == STROBE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: tb/tb_output_pad_streamer.sv
// Self-checking bench for output_pad_streamer: a timeline model of the pad stream plus directed literal checks.
// Honours OUTPUT_PARITY_EN the same way as the design build.
module tb_output_pad_streamer;
    localparam int NP    = 32;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int DW    = NP - 1;

`ifdef OUTPUT_PARITY_EN
    localparam logic [DW-1:0] SINGLE_DATA = 31'h52345678;
    localparam logic          PAR_A       = 1'b0;
    localparam logic          PAR_B       = 1'b1;
`else
    localparam logic [DW-1:0] SINGLE_DATA = 31'h12345678;
    localparam logic          PAR_A       = 1'b1;
    localparam logic          PAR_B       = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NP-1:0] output_out;
    logic [2:0]    fifo_level;
    logic          busy;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 1'b0;

    output_pad_streamer #(
        .NUM_OUTPUT_PADS(NP),
        .FIFO_DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .output_out(output_out),
        .fifo_level(fifo_level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] padWord(input logic [DW-1:0] d);
`ifdef OUTPUT_PARITY_EN
        return {^d[DW-2:0], d[DW-2:0]};
`else
        return d;
`endif
    endfunction

    // Timeline model: each word occupies the pads for HOLD+2 edges starting at the edge that takes it.
    logic [DW-1:0] mQ[$];
    int            mEdge   = 0;
    int            mFreeAt = 0;
    int            mStart  = -1;
    logic [DW-1:0] mWord   = '0;

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit take;
        if (!rst_n) begin
            mQ.delete();
            mFreeAt = 0;
            mStart  = -1;
            mWord   = '0;
        end else begin
            mEdge++;
            acc  = in_valid && (mQ.size() < DEPTH);
            take = (mEdge >= mFreeAt) && (mQ.size() > 0);
            if (take) begin
                mWord   = mQ.pop_front();
                mStart  = mEdge;
                mFreeAt = mEdge + HOLD + 2;
            end
            if (acc) begin
                mQ.push_back(padWord(in_data));
            end
        end
    end

    always @(negedge clk) begin
        logic expStrobe;
        logic expBusy;
        if (checkEn) begin
            expStrobe = (mStart >= 0) && (mEdge >= mStart + 1) && (mEdge <= mStart + HOLD);
            expBusy   = (mQ.size() > 0) || ((mStart >= 0) && (mEdge < mFreeAt));
            checkOutput("model pads", 64'(output_out), 64'({expStrobe, mWord}));
            checkOutput("model level", 64'(fifo_level), 64'(mQ.size()));
            checkOutput("model in_ready", 64'(in_ready), 64'(mQ.size() < DEPTH));
            checkOutput("model busy", 64'(busy), 64'(expBusy));
        end
    end

    // Records every strobe rise with the data shown at that moment.
    int            cyc     = 0;
    logic          prevStb = 1'b0;
    int            riseCyc[$];
    logic [DW-1:0] riseWord[$];

    always @(negedge clk) begin
        cyc++;
        if (output_out[DW] === 1'b1 && prevStb !== 1'b1) begin
            riseCyc.push_back(cyc);
            riseWord.push_back(output_out[DW-1:0]);
        end
        prevStb = output_out[DW];
    end

    task automatic applyStimulus(input logic [DW-1:0] word);
        in_valid = 1'b1;
        in_data  = word;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while (busy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait idle", 64'(busy), 64'(0));
    endtask

    initial begin
        int         idx;
        int         base;
        int         n;
        bit         acc;
        bit         sawFull;
        logic [2:0] lvl[12];

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 12; i++) lvl[i] = '0;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset pads", 64'(output_out), 64'(0));
        checkOutput("reset in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single word");
        applyStimulus(31'h12345678);
        checkOutput("single level E0", 64'(fifo_level), 64'(1));
        @(negedge clk);
        checkOutput("single data E1", 64'(output_out), 64'({1'b0, SINGLE_DATA}));
        @(negedge clk);
        checkOutput("single strobe E2", 64'(output_out), 64'({1'b1, SINGLE_DATA}));
        repeat (3) @(negedge clk);
        checkOutput("single strobe E5", 64'(output_out), 64'({1'b1, SINGLE_DATA}));
        @(negedge clk);
        checkOutput("single gap E6", 64'(output_out), 64'({1'b0, SINGLE_DATA}));
        checkOutput("single busy E6", 64'(busy), 64'(1));
        @(negedge clk);
        checkOutput("single idle E7", 64'(busy), 64'(0));

        $display("[TB] burst of six");
        base     = riseCyc.size();
        idx      = 0;
        sawFull  = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(1);
        for (int k = 0; k < 12 && idx < 6; k++) begin
            acc = in_ready;
            if (!acc) sawFull = 1'b1;
            @(negedge clk);
            lvl[k] = fifo_level;
            if (acc) begin
                idx++;
                in_data = DW'(idx + 1);
                if (idx == 6) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checkOutput("burst accepted", 64'(idx), 64'(6));
        checkOutput("burst in_ready dropped", 64'(sawFull), 64'(1));
        checkOutput("burst level E3", 64'(lvl[3]), 64'(3));
        checkOutput("burst level E4 full", 64'(lvl[4]), 64'(4));
        checkOutput("burst level E7 gap pop", 64'(lvl[7]), 64'(3));
        checkOutput("burst level E8 push", 64'(lvl[8]), 64'(4));
        waitIdle(100);
        n = riseCyc.size() - base;
        checkOutput("burst rise count", 64'(n), 64'(6));
        for (int i = 0; i < n && i < 6; i++) begin
            checkOutput($sformatf("burst word %0d", i + 1), 64'(riseWord[base + i]), 64'(padWord(DW'(i + 1))));
            if (i > 0) begin
                checkOutput($sformatf("burst spacing %0d", i), 64'(riseCyc[base + i] - riseCyc[base + i - 1]), 64'(HOLD + 2));
            end
        end

        $display("[TB] reset during strobe");
        in_valid = 1'b1;
        in_data  = DW'('h111);
        @(negedge clk);
        in_data = DW'('h222);
        @(negedge clk);
        in_data = DW'('h333);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pre-reset level", 64'(fifo_level), 64'(2));
        @(negedge clk);
        checkOutput("pre-reset strobe", 64'(output_out[DW]), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset pads", 64'(output_out), 64'(0));
        checkOutput("async reset level", 64'(fifo_level), 64'(0));
        checkOutput("async reset in_ready", 64'(in_ready), 64'(1));
        checkOutput("async reset busy", 64'(busy), 64'(0));
        base = riseCyc.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("no emit after reset", 64'(riseCyc.size() - base), 64'(0));
        checkOutput("pads quiet after reset", 64'(output_out), 64'(0));

        $display("[TB] top data bit");
        applyStimulus(31'h7FFFFFFF);
        @(negedge clk);
        checkOutput("top bit all ones", 64'(output_out[DW-1]), 64'(PAR_A));
        waitIdle(50);
        applyStimulus(31'h00000007);
        @(negedge clk);
        checkOutput("top bit seven", 64'(output_out[DW-1]), 64'(PAR_B));
        waitIdle(50);

        $display("[TB] random traffic");
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 150; c++) begin
                in_valid = ($urandom_range(0, 99) < ((seg == 0) ? 20 : (seg == 1) ? 60 : 95));
                in_data  = DW'($urandom);
                if (seg == 1 && c == 70) begin
                    #($urandom_range(1, 8)) rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        waitIdle(200);

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
